// File: rtl/javk_bus_pkg.sv
// Shared types and constants for the JAVK system bus arbiter.
package javk_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } arb_state_t;

   localparam int JAVK_ADDR_W = 16;
   localparam int JAVK_DATA_W = 8;

   // Values the bus rests at whenever nobody owns it.
   localparam logic [JAVK_ADDR_W-1:0] PARK_ADDR = '0;
   localparam logic                   PARK_RW   = 1'b1;
   localparam logic [JAVK_DATA_W-1:0] PARK_DATA = '0;
   localparam logic                   PARK_OE   = 1'b0;

   // Width of an index/counter covering 0..n-1, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/javk_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module javk_rr_pick
   import javk_bus_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]          req,
   input  logic [idx_w(N)-1:0]   ptr,
   output logic [N-1:0]          win,
   output logic [idx_w(N)-1:0]   win_idx,
   output logic                  any
);

   localparam int IW = idx_w(N);

   logic          found;
   logic [IW-1:0] cand;

   // Scan from ptr upward with wrap; the first requesting index is taken.
   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int off = 0; off < N; off++) begin
         cand = IW'((int'(ptr) + off) % N);
         if (!found && req[cand]) begin
            found     = 1'b1;
            win[cand] = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/javk_bus_arbiter.sv
// Round-robin owner arbitration for the JAVK bus with a parked turnaround
// cycle between owners and a burst cap while others are waiting.
//
//  state | meaning
//  IDLE  | bus parked, no grant
//  OWN   | one master granted, bus follows its address/direction/data
//  TURN  | single parked cycle after release or preemption
module javk_bus_arbiter
   import javk_bus_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int MAX_HOLD  = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_MASTERS-1:0]               req,
   output logic [N_MASTERS-1:0]               gnt,
   input  logic [JAVK_ADDR_W*N_MASTERS-1:0]   m_addr,
   input  logic [N_MASTERS-1:0]               m_rw,
   input  logic [JAVK_DATA_W*N_MASTERS-1:0]   m_wdata,
   output logic [JAVK_ADDR_W-1:0]             addrbus,
   output logic                               rw,
   output logic [JAVK_DATA_W-1:0]             data_out,
   output logic                               data_oe,
   input  logic [JAVK_DATA_W-1:0]             data_in,
   output logic [JAVK_DATA_W-1:0]             rdata,
   output logic                               busy
);

   localparam int IW        = idx_w(N_MASTERS);
   localparam int CW        = idx_w(MAX_HOLD);
   localparam bit HOLD_ON   = (MAX_HOLD != 0);
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

   arb_state_t             state, state_nx;
   logic [N_MASTERS-1:0]   gnt_nx;
   logic [IW-1:0]          gidx, gidx_nx;
   logic [IW-1:0]          ptr, ptr_nx;
   logic [CW-1:0]          cnt, cnt_nx;

   logic [N_MASTERS-1:0]   pick_win;
   logic [IW-1:0]          pick_idx;
   logic                   pick_any;
   logic [IW-1:0]          ptr_after_pick;
   logic                   owner_req;
   logic                   others;
   logic                   at_last;

   javk_rr_pick #(.N(N_MASTERS)) u_pick (
      .req     (req),
      .ptr     (ptr),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   assign ptr_after_pick = (pick_idx == IW'(N_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
   assign owner_req      = req[gidx];
   assign others         = |(req & ~gnt);
   assign at_last        = HOLD_ON && (cnt == CW'(HOLD_LAST));

   // Next state, grant, owner index, round-robin pointer and hold counter.
   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      gidx_nx  = gidx;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      unique case (state)
         IDLE, TURN: begin
            if (pick_any) begin
               state_nx = OWN;
               gnt_nx   = pick_win;
               gidx_nx  = pick_idx;
               ptr_nx   = ptr_after_pick;
               cnt_nx   = '0;
            end else begin
               state_nx = IDLE;
            end
         end
         OWN: begin
            // Release and preemption collapse into the same single TURN.
            if (!owner_req || (at_last && others)) begin
               state_nx = TURN;
               gnt_nx   = '0;
            end else if (HOLD_ON && !at_last) begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = '0;
         end
      endcase
   end

   // State registers; rdata samples the bus every edge regardless of state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         gidx  <= '0;
         ptr   <= '0;
         cnt   <= '0;
         rdata <= '0;
      end else begin
         state <= state_nx;
         gnt   <= gnt_nx;
         gidx  <= gidx_nx;
         ptr   <= ptr_nx;
         cnt   <= cnt_nx;
         rdata <= data_in;
      end
   end

   // Bus follows the owner in OWN and is parked otherwise.
   always_comb begin
      addrbus  = PARK_ADDR;
      rw       = PARK_RW;
      data_out = PARK_DATA;
      data_oe  = PARK_OE;
      if (state == OWN) begin
         for (int i = 0; i < N_MASTERS; i++) begin
            if (gidx == IW'(i)) begin
               addrbus  = m_addr[JAVK_ADDR_W*i +: JAVK_ADDR_W];
               rw       = m_rw[i];
               data_out = m_wdata[JAVK_DATA_W*i +: JAVK_DATA_W];
               data_oe  = ~m_rw[i];
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_javk_bus_arbiter.sv
// Cycle-scripted bench: each step drives inputs, queues the outputs the bus
// must show in that cycle, then pops and compares them before the next edge.
module tb_javk_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [31:0] m_addr;
   logic [1:0]  m_rw;
   logic [15:0] m_wdata;
   logic [15:0] addrbus;
   logic        rw;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [7:0]  data_in;
   logic [7:0]  rdata;
   logic        busy;

   int n_chk = 0;
   int n_bad = 0;

   // Bus selector values for expectations.
   localparam int PARK = 0;
   localparam int M0   = 1;
   localparam int M1   = 2;

   typedef struct {
      string       tag;
      logic [1:0]  gnt;
      logic [15:0] addr;
      logic        rw;
      logic        oe;
      logic [7:0]  dout;
      logic        busy;
      logic [7:0]  rd;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] exp_rd = 8'h00;

   javk_bus_arbiter #(.N_MASTERS(2), .MAX_HOLD(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .gnt      (gnt),
      .m_addr   (m_addr),
      .m_rw     (m_rw),
      .m_wdata  (m_wdata),
      .addrbus  (addrbus),
      .rw       (rw),
      .data_out (data_out),
      .data_oe  (data_oe),
      .data_in  (data_in),
      .rdata    (rdata),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One bus cycle: drive, queue expectation, compare mid-cycle, advance.
   task automatic cyc(input string tag, input logic r, input logic [1:0] rq,
                      input logic [7:0] din, input logic [1:0] eg,
                      input int sel, input logic eb);
      exp_t e;
      rst     = r;
      req     = rq;
      data_in = din;
      e.tag  = tag;
      e.gnt  = eg;
      e.busy = eb;
      e.rd   = exp_rd;
      case (sel)
         M0:      begin e.addr = 16'h1234; e.rw = 1'b1; e.oe = 1'b0; e.dout = 8'h00; end
         M1:      begin e.addr = 16'h8000; e.rw = 1'b0; e.oe = 1'b1; e.dout = 8'hA5; end
         default: begin e.addr = 16'h0000; e.rw = 1'b1; e.oe = 1'b0; e.dout = 8'h00; end
      endcase
      sb.push_back(e);
      exp_rd = r ? 8'h00 : din;
      #2;
      e = sb.pop_front();
      chk({e.tag, ".gnt"},   32'(gnt),      32'(e.gnt));
      chk({e.tag, ".addr"},  32'(addrbus),  32'(e.addr));
      chk({e.tag, ".rw"},    32'(rw),       32'(e.rw));
      chk({e.tag, ".oe"},    32'(data_oe),  32'(e.oe));
      chk({e.tag, ".dout"},  32'(data_out), 32'(e.dout));
      chk({e.tag, ".busy"},  32'(busy),     32'(e.busy));
      chk({e.tag, ".rdata"}, 32'(rdata),    32'(e.rd));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      req     = 2'b00;
      data_in = 8'h00;
      m_addr  = {16'h8000, 16'h1234};
      m_rw    = 2'b01;
      m_wdata = {8'hA5, 8'h00};
      repeat (2) @(posedge clk);
      #1;

      // Reset, first grant, read data, reset mid-burst, release.
      cyc("rst",     1'b1, 2'b00, 8'h00, 2'b00, PARK, 1'b0);
      cyc("req0",    1'b0, 2'b01, 8'h00, 2'b00, PARK, 1'b0);
      cyc("own0a",   1'b0, 2'b01, 8'h3C, 2'b01, M0,   1'b1);
      cyc("own0b",   1'b1, 2'b01, 8'h77, 2'b01, M0,   1'b1);
      cyc("postrst", 1'b0, 2'b01, 8'h00, 2'b00, PARK, 1'b0);
      cyc("own0c",   1'b0, 2'b00, 8'h5A, 2'b01, M0,   1'b1);
      cyc("turn0",   1'b0, 2'b00, 8'h00, 2'b00, PARK, 1'b1);
      cyc("idle0",   1'b0, 2'b00, 8'h00, 2'b00, PARK, 1'b0);

      // Reset-time tie goes to the CPU, then master 1 writes after TURN.
      cyc("rst2",    1'b1, 2'b00, 8'h00, 2'b00, PARK, 1'b0);
      cyc("tie",     1'b0, 2'b11, 8'h00, 2'b00, PARK, 1'b0);
      cyc("tie_own", 1'b0, 2'b10, 8'h00, 2'b01, M0,   1'b1);
      cyc("tie_trn", 1'b0, 2'b10, 8'h00, 2'b00, PARK, 1'b1);
      cyc("wr1a",    1'b0, 2'b10, 8'h00, 2'b10, M1,   1'b1);
      cyc("wr1b",    1'b0, 2'b00, 8'h00, 2'b10, M1,   1'b1);
      cyc("wr_trn",  1'b0, 2'b00, 8'h00, 2'b00, PARK, 1'b1);
      cyc("wr_idle", 1'b0, 2'b00, 8'h00, 2'b00, PARK, 1'b0);

      // Hold cap of 4 with master 1 waiting; pointer now favours master 0.
      cyc("cap_req", 1'b0, 2'b01, 8'h00, 2'b00, PARK, 1'b0);
      for (int i = 0; i < 4; i++)
         cyc($sformatf("cap_own0_%0d", i), 1'b0, 2'b11, 8'h00, 2'b01, M0, 1'b1);
      cyc("cap_trn", 1'b0, 2'b11, 8'h00, 2'b00, PARK, 1'b1);
      cyc("cap_m1a", 1'b0, 2'b11, 8'h00, 2'b10, M1,   1'b1);
      cyc("cap_m1b", 1'b0, 2'b11, 8'h00, 2'b10, M1,   1'b1);
      cyc("cap_m1c", 1'b0, 2'b01, 8'h00, 2'b10, M1,   1'b1);
      cyc("cap_tr2", 1'b0, 2'b01, 8'h00, 2'b00, PARK, 1'b1);

      // Lone requester keeps the bus well past the cap.
      for (int i = 0; i < 20; i++)
         cyc($sformatf("solo_%0d", i), 1'b0, 2'b01, 8'(i), 2'b01, M0, 1'b1);
      cyc("solo_end", 1'b0, 2'b00, 8'h00, 2'b01, M0,   1'b1);
      cyc("solo_trn", 1'b0, 2'b00, 8'h00, 2'b00, PARK, 1'b1);
      cyc("solo_idl", 1'b0, 2'b00, 8'h00, 2'b00, PARK, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
